// File: rtl/fetch_sequencer_pkg.sv
// Shared front-end definitions: fetch FSM states, datapath width and reset PC.
package fetch_sequencer_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h1C00_0000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_e;

    // Fetch targets are word aligned; the two low bits are ignored.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pair_buffer.sv
// Output register for the fetched instruction pair; loads a response, holds
// it while the decoder stalls and drops the slot enables on consume/flush.
module fetch_pair_buffer
    import fetch_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_1_i,
    input  logic [XLEN-1:0] inst_2_i,
    output logic [XLEN-1:0] pc_1_o,
    output logic [XLEN-1:0] pc_2_o,
    output logic [XLEN-1:0] inst_1_o,
    output logic [XLEN-1:0] inst_2_o,
    output logic            en_1_o,
    output logic            en_2_o
);

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        localparam logic [XLEN-1:0] OFFSET = XLEN'(4 * gi);

        logic [XLEN-1:0] pc_q;
        logic [XLEN-1:0] inst_q;
        logic            en_q;

        // The second slot is only valid when the pair does not straddle an
        // 8-byte boundary, i.e. the base PC sits in the low word.
        always_ff @(posedge clk) begin
            if (!rst) begin
                pc_q   <= '0;
                inst_q <= '0;
                en_q   <= 1'b0;
            end else if (load_i) begin
                pc_q   <= pc_i + OFFSET;
                inst_q <= (gi == 0) ? inst_1_i : inst_2_i;
                en_q   <= (gi == 0) ? 1'b1 : !pc_i[2];
            end else if (clear_i) begin
                en_q   <= 1'b0;
            end
        end
    end

    assign pc_1_o   = g_slot[0].pc_q;
    assign pc_2_o   = g_slot[1].pc_q;
    assign inst_1_o = g_slot[0].inst_q;
    assign inst_2_o = g_slot[1].inst_q;
    assign en_1_o   = g_slot[0].en_q;
    assign en_2_o   = g_slot[1].en_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding I-cache request, a held fetch
// pair for the decoder, BPU redirect on consume and backend flush.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_target,
    input  logic            stall,
    input  logic            bpu_valid,
    input  logic            bpu_taken,
    input  logic [XLEN-1:0] bpu_target,
    output logic            icache_req,
    output logic [XLEN-1:0] icache_pc,
    input  logic            icache_ready,
    input  logic            icache_rvalid,
    input  logic [XLEN-1:0] icache_inst_1,
    input  logic [XLEN-1:0] icache_inst_2,
    output logic [XLEN-1:0] pc_1_o,
    output logic [XLEN-1:0] pc_2_o,
    output logic [XLEN-1:0] inst_1_o,
    output logic [XLEN-1:0] inst_2_o,
    output logic            fetch_inst_1_en,
    output logic            fetch_inst_2_en
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            icache_req_q;
    logic [XLEN-1:0] icache_pc_q;
    logic [XLEN-1:0] flush_pc;
    logic [XLEN-1:0] seq_pc;
    logic            buf_load;
    logic            buf_clear;

    assign flush_pc = word_align(flush_target);
    assign seq_pc   = (bpu_valid && bpu_taken) ? word_align(bpu_target)
                                               : pc_q + (pc_q[2] ? 32'd4 : 32'd8);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                pc_d    = flush ? flush_pc : RESET_PC;
            end
            REQ: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = icache_ready ? DRAIN : REQ;
                end else if (icache_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = icache_rvalid ? REQ : DRAIN;
                end else if (icache_rvalid) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = REQ;
                end else if (!stall) begin
                    pc_d    = seq_pc;
                    state_d = REQ;
                end
            end
            DRAIN: begin
                // The stale response still retires the outstanding request,
                // even when a further flush arrives with it.
                if (flush) begin
                    pc_d = flush_pc;
                end
                if (icache_rvalid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            icache_req_q <= 1'b0;
            icache_pc_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            icache_req_q <= (state_d == REQ);
            icache_pc_q  <= (state_d == REQ) ? pc_d : '0;
        end
    end

    assign icache_req = icache_req_q;
    assign icache_pc  = icache_pc_q;

    assign buf_load  = (state_q == WAIT) && icache_rvalid && !flush;
    assign buf_clear = (state_q == HOLD) && (flush || !stall);

    fetch_pair_buffer u_pair_buffer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (buf_load),
        .clear_i  (buf_clear),
        .pc_i     (pc_q),
        .inst_1_i (icache_inst_1),
        .inst_2_i (icache_inst_2),
        .pc_1_o   (pc_1_o),
        .pc_2_o   (pc_2_o),
        .inst_1_o (inst_1_o),
        .inst_2_o (inst_2_o),
        .en_1_o   (fetch_inst_1_en),
        .en_2_o   (fetch_inst_2_en)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written flush/reset
// sequences, then random traffic against a transaction-level fetch model.
module tb_fetch_sequencer;

    localparam logic [31:0] RP = 32'h1C00_0000;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] flush_target;
    logic        stall;
    logic        bpu_valid;
    logic        bpu_taken;
    logic [31:0] bpu_target;
    logic        icache_req;
    logic [31:0] icache_pc;
    logic        icache_ready;
    logic        icache_rvalid;
    logic [31:0] icache_inst_1;
    logic [31:0] icache_inst_2;
    logic [31:0] pc_1_o;
    logic [31:0] pc_2_o;
    logic [31:0] inst_1_o;
    logic [31:0] inst_2_o;
    logic        fetch_inst_1_en;
    logic        fetch_inst_2_en;

    int n_vec = 0;
    int n_bad = 0;

    fetch_sequencer #(.RESET_PC(RP)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .flush_target    (flush_target),
        .stall           (stall),
        .bpu_valid       (bpu_valid),
        .bpu_taken       (bpu_taken),
        .bpu_target      (bpu_target),
        .icache_req      (icache_req),
        .icache_pc       (icache_pc),
        .icache_ready    (icache_ready),
        .icache_rvalid   (icache_rvalid),
        .icache_inst_1   (icache_inst_1),
        .icache_inst_2   (icache_inst_2),
        .pc_1_o          (pc_1_o),
        .pc_2_o          (pc_2_o),
        .inst_1_o        (inst_1_o),
        .inst_2_o        (inst_2_o),
        .fetch_inst_1_en (fetch_inst_1_en),
        .fetch_inst_2_en (fetch_inst_2_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          chk;     // 0: none, 1: normal, 2: reset state
        logic        e_req;
        logic [31:0] e_ipc;
        logic        e_en1;
        logic        e_en2;
        logic [31:0] e_pc1;
        logic [31:0] e_i1;
        logic        rst_n;
        logic        stl;
        logic        bpu;
        logic [31:0] btgt;
        logic        rdy;
        logic        rv;
        logic [31:0] i1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int chk, input logic e_req, input logic [31:0] e_ipc,
                                input logic e_en1, input logic e_en2, input logic [31:0] e_pc1,
                                input logic [31:0] e_i1, input logic rst_n, input logic stl,
                                input logic bpu, input logic [31:0] btgt, input logic rdy,
                                input logic rv, input logic [31:0] i1);
        vec_t v;
        v.chk = chk; v.e_req = e_req; v.e_ipc = e_ipc; v.e_en1 = e_en1; v.e_en2 = e_en2;
        v.e_pc1 = e_pc1; v.e_i1 = e_i1; v.rst_n = rst_n; v.stl = stl; v.bpu = bpu;
        v.btgt = btgt; v.rdy = rdy; v.rv = rv; v.i1 = i1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        flush = 1'b0; flush_target = '0; stall = 1'b0;
        bpu_valid = 1'b0; bpu_taken = 1'b0; bpu_target = '0;
        icache_ready = 1'b0; icache_rvalid = 1'b0;
        icache_inst_1 = '0; icache_inst_2 = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"}, icache_req, 0);
        check({tag, "_en"}, {fetch_inst_1_en, fetch_inst_2_en}, 0);
        check({tag, "_pc1"}, pc_1_o, 0);
        check({tag, "_pc2"}, pc_2_o, 0);
        check({tag, "_inst1"}, inst_1_o, 0);
        check({tag, "_inst2"}, inst_2_o, 0);
    endtask

    // Contents of the modelled instruction memory.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Random-phase model state
    logic [31:0] exp_pc;
    logic [31:0] out_pc;
    logic [31:0] nxt;
    bit          outst, live, present, accepted, resp;
    int          lat, quiet;

    initial begin
        rst = 1'b0;
        clear_inputs();

        // ---------------- table-driven vectors ----------------
        tbl.push_back(mk(2,0,0,0,0,0,0,                         0,0,0,0,          0,0,0));
        tbl.push_back(mk(2,0,0,0,0,0,0,                         1,0,0,0,          0,0,0));
        tbl.push_back(mk(1,1,RP,0,0,0,0,                        1,0,0,0,          1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,                         1,0,0,0,          0,1,32'hA000_0000));
        tbl.push_back(mk(1,0,0,1,1,RP,32'hA000_0000,            1,0,0,0,          0,0,0));
        tbl.push_back(mk(1,1,RP+8,0,0,0,0,                      1,0,0,0,          1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,                         1,0,0,0,          0,1,32'hB000_0000));
        tbl.push_back(mk(1,0,0,1,1,RP+8,32'hB000_0000,          0,1,0,0,          0,0,0));
        tbl.push_back(mk(2,0,0,0,0,0,0,                         1,0,0,0,          0,0,0));
        tbl.push_back(mk(1,1,RP,0,0,0,0,                        1,0,0,0,          1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,                         1,0,0,0,          0,1,32'hC000_0000));
        tbl.push_back(mk(1,0,0,1,1,RP,32'hC000_0000,            1,0,1,RP+32'h104, 0,0,0));
        tbl.push_back(mk(1,1,RP+32'h104,0,0,0,0,                1,0,0,0,          1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,                         1,0,0,0,          0,1,32'hD000_0000));
        tbl.push_back(mk(1,0,0,1,0,RP+32'h104,32'hD000_0000,    1,0,0,0,          0,0,0));
        tbl.push_back(mk(1,1,RP+32'h108,0,0,0,0,                1,0,0,0,          1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,                         1,0,0,0,          0,1,32'hE000_0000));
        tbl.push_back(mk(1,0,0,1,1,RP+32'h108,32'hE000_0000,    1,1,0,0,          0,0,0));
        tbl.push_back(mk(1,0,0,1,1,RP+32'h108,32'hE000_0000,    1,1,0,0,          0,0,0));
        tbl.push_back(mk(1,0,0,1,1,RP+32'h108,32'hE000_0000,    1,1,0,0,          0,0,0));
        tbl.push_back(mk(1,0,0,1,1,RP+32'h108,32'hE000_0000,    1,0,0,0,          0,0,0));
        tbl.push_back(mk(1,1,RP+32'h110,0,0,0,0,                1,0,0,0,          0,0,0));
        tbl.push_back(mk(1,1,RP+32'h110,0,0,0,0,                1,0,0,0,          0,0,0));

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            if (tbl[k].chk == 2) begin
                check_reset_state("tbl_reset");
            end else if (tbl[k].chk == 1) begin
                check("tbl_req", icache_req, tbl[k].e_req);
                if (tbl[k].e_req) check("tbl_icache_pc", icache_pc, tbl[k].e_ipc);
                check("tbl_en1", fetch_inst_1_en, tbl[k].e_en1);
                check("tbl_en2", fetch_inst_2_en, tbl[k].e_en2);
                if (tbl[k].e_en1) begin
                    check("tbl_pc1", pc_1_o, tbl[k].e_pc1);
                    check("tbl_pc2", pc_2_o, tbl[k].e_pc1 + 32'd4);
                    check("tbl_inst1", inst_1_o, tbl[k].e_i1);
                    check("tbl_inst2", inst_2_o, tbl[k].e_i1 + 32'd1);
                end
            end
            $display("vec %0d: req=%0b icache_pc=%08h en=%0b%0b pc1=%08h inst1=%08h",
                     k, icache_req, icache_pc, fetch_inst_1_en, fetch_inst_2_en, pc_1_o, inst_1_o);
            rst           = tbl[k].rst_n;
            flush         = 1'b0;
            stall         = tbl[k].stl;
            bpu_valid     = tbl[k].bpu;
            bpu_taken     = tbl[k].bpu;
            bpu_target    = tbl[k].btgt;
            icache_ready  = tbl[k].rdy;
            icache_rvalid = tbl[k].rv;
            icache_inst_1 = tbl[k].i1;
            icache_inst_2 = tbl[k].i1 + 32'd1;
        end

        // ---------------- flush in WAIT, stale response ----------------
        @(negedge clk); clear_inputs(); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); check("seq_req_after_reset", icache_pc, RP); icache_ready = 1'b1;
        @(negedge clk); check("seq_wait_req", icache_req, 0);
        icache_ready = 1'b0; flush = 1'b1; flush_target = 32'h1C00_0203;
        @(negedge clk); check("seq_drain_req", icache_req, 0);
        check("seq_drain_en", {fetch_inst_1_en, fetch_inst_2_en}, 0);
        flush = 1'b0;
        @(negedge clk); check("seq_drain_en2", {fetch_inst_1_en, fetch_inst_2_en}, 0);
        icache_rvalid = 1'b1; icache_inst_1 = 32'hDEAD_BEEF; icache_inst_2 = 32'hDEAD_BEEF;
        @(negedge clk); icache_rvalid = 1'b0;
        check("seq_stale_en", {fetch_inst_1_en, fetch_inst_2_en}, 0);
        check("seq_flush_req", icache_req, 1);
        check("seq_flush_pc", icache_pc, 32'h1C00_0200);
        icache_ready = 1'b1;
        @(negedge clk); icache_ready = 1'b0;
        icache_rvalid = 1'b1; icache_inst_1 = 32'h600D_0000; icache_inst_2 = 32'h600D_0001;
        @(negedge clk); icache_rvalid = 1'b0;
        check("seq_hold_en1", fetch_inst_1_en, 1);
        check("seq_hold_pc1", pc_1_o, 32'h1C00_0200);
        check("seq_hold_inst1", inst_1_o, 32'h600D_0000);
        // ---------------- flush vs bpu_taken vs stall ----------------
        flush = 1'b1; flush_target = 32'h1C00_0300;
        bpu_valid = 1'b1; bpu_taken = 1'b1; bpu_target = 32'h1C00_0400; stall = 1'b1;
        @(negedge clk); clear_inputs();
        check("seq_flushwin_en", {fetch_inst_1_en, fetch_inst_2_en}, 0);
        check("seq_flushwin_req", icache_req, 1);
        check("seq_flushwin_pc", icache_pc, 32'h1C00_0300);
        icache_ready = 1'b1;
        // ---------------- reset in WAIT, late response ----------------
        @(negedge clk); icache_ready = 1'b0; rst = 1'b0;
        @(negedge clk); check_reset_state("seq_reset_wait");
        rst = 1'b1; icache_rvalid = 1'b1; icache_inst_1 = 32'hBAD0_0000;
        @(negedge clk);
        check("seq_late_req", icache_req, 1);
        check("seq_late_pc", icache_pc, RP);
        check("seq_late_en", {fetch_inst_1_en, fetch_inst_2_en}, 0);
        @(negedge clk);
        check("seq_late_en2", {fetch_inst_1_en, fetch_inst_2_en}, 0);
        check("seq_late_pc2", icache_pc, RP);
        clear_inputs();

        // ---------------- random traffic vs. fetch model ----------------
        exp_pc = RP; out_pc = '0; outst = 0; live = 0; present = 0; lat = 0; quiet = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (present) begin
                quiet = 0;
                check("rnd_en1", fetch_inst_1_en, 1);
                check("rnd_en2", fetch_inst_2_en, !exp_pc[2]);
                check("rnd_pc1", pc_1_o, exp_pc);
                check("rnd_pc2", pc_2_o, exp_pc + 32'd4);
                check("rnd_inst1", inst_1_o, mem(exp_pc));
                check("rnd_inst2", inst_2_o, mem(exp_pc + 32'd4));
                check("rnd_req_while_hold", icache_req, 0);
            end else begin
                quiet++;
                check("rnd_idle_en", {fetch_inst_1_en, fetch_inst_2_en}, 0);
                if (quiet > 200) begin
                    n_vec++; n_bad++;
                    $display("FAIL rnd_progress: got no fetch pair for %0d cycles expected one", quiet);
                    break;
                end
            end
            if (icache_req) begin
                check("rnd_req_pc", icache_pc, exp_pc);
                check("rnd_one_outstanding", outst, 0);
            end

            flush        = ($urandom_range(0, 11) == 0);
            flush_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                                       : (32'h1C00_0000 | ($urandom() & 32'hFFFF));
            stall        = ($urandom_range(0, 2) == 0);
            bpu_valid    = $urandom_range(0, 1);
            bpu_taken    = ($urandom_range(0, 2) == 0);
            bpu_target   = 32'h1C00_0000 | ($urandom() & 32'hFFFF);
            icache_ready = $urandom_range(0, 1);
            if (outst) begin
                icache_rvalid = (lat == 0);
                icache_inst_1 = mem(out_pc);
                icache_inst_2 = mem(out_pc + 32'd4);
            end else begin
                icache_rvalid = ($urandom_range(0, 4) == 0);
                icache_inst_1 = $urandom();
                icache_inst_2 = $urandom();
            end

            accepted = icache_req && icache_ready;
            resp     = icache_rvalid && outst;
            if (flush) begin
                exp_pc  = flush_target & 32'hFFFF_FFFC;
                present = 0;
                live    = 0;
            end else begin
                if (present && !stall) begin
                    if (bpu_valid && bpu_taken) nxt = bpu_target & 32'hFFFF_FFFC;
                    else                        nxt = exp_pc + (exp_pc[2] ? 32'd4 : 32'd8);
                    exp_pc  = nxt;
                    present = 0;
                end
                if (resp && live) begin
                    present = 1;
                    $display("pair pc=%08h inst=%08h/%08h", exp_pc, mem(exp_pc), mem(exp_pc + 32'd4));
                end
            end
            if (resp)            outst = 0;
            else if (outst && lat > 0) lat--;
            if (accepted) begin
                outst  = 1;
                out_pc = icache_pc;
                lat    = $urandom_range(0, 2);
                live   = !flush;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have the parameter RESET_PC, default 32'h1C000000, giving the first fetch address after reset.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have the ports flush (input, 1 bit) and flush_target (input, 32 bits): a backend redirect and its target PC.
REQ-005 The block SHALL have the port stall, input, 1 bit: the decoder cannot accept the held pair this cycle.
REQ-006 The block SHALL have the ports bpu_valid (input, 1), bpu_taken (input, 1) and bpu_target (input, 32): the BPU prediction for the pair currently presented.
REQ-007 The block SHALL have the ports icache_req (output, 1) and icache_pc (output, 32): a fetch request and its base PC.
REQ-008 The block SHALL have the ports icache_ready (input, 1) and icache_rvalid (input, 1): request accepted; response valid.
REQ-009 The block SHALL have the ports icache_inst_1 and icache_inst_2, both inputs, 32 bits each: the response words at base and base+4.
REQ-010 The block SHALL have the ports pc_1_o, pc_2_o, inst_1_o and inst_2_o, all outputs, 32 bits each: the held fetch pair.
REQ-011 The block SHALL have the ports fetch_inst_1_en and fetch_inst_2_en, outputs, 1 bit each: per-slot valid.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, REQ, WAIT, HOLD and DRAIN, and SHALL allow one outstanding cache request at most.
REQ-013 IDLE SHALL last exactly one cycle after reset release, then go to REQ with pc = RESET_PC.
REQ-014 In REQ, icache_req=1 and icache_pc=pc; icache_ready=1 SHALL go to WAIT, otherwise the FSM stays in REQ.
REQ-015 In WAIT, icache_rvalid=1 SHALL capture the pair into the output register and go to HOLD, with outputs visible the next cycle.
REQ-016 Slot rule: pc_1_o=pc, pc_2_o=pc+4, fetch_inst_1_en=1 in HOLD, and fetch_inst_2_en=1 in HOLD only when pc[2]==0.
REQ-017 In HOLD with stall=1, all outputs SHALL be held unchanged.
REQ-018 In HOLD with stall=0, the pair SHALL be consumed and the FSM SHALL go to REQ.
REQ-019 On consumption, next pc SHALL be bpu_target when bpu_valid&bpu_taken, else pc+8 when pc[2]==0, else pc+4, using 32-bit wrapping arithmetic.
REQ-020 flush SHALL take priority over bpu_taken and stall in every state; targets SHALL have bits[1:0] forced to 0.
REQ-021 flush in HOLD SHALL clear both enables next cycle, set pc=flush_target and go to REQ.
REQ-022 flush in REQ with icache_ready=0 SHALL set pc=flush_target and stay in REQ; the old request is not issued.
REQ-023 flush in REQ with icache_ready=1 SHALL set pc=flush_target and go to DRAIN.
REQ-024 flush in WAIT without rvalid SHALL go to DRAIN; flush in WAIT with rvalid SHALL discard the data and go to REQ; pc=flush_target in both cases.
REQ-025 DRAIN SHALL hold icache_req=0 and enables=0; rvalid there SHALL be discarded and go to REQ.
REQ-026 flush in DRAIN SHALL update pc only, remaining in DRAIN.
REQ-027 rvalid outside WAIT and DRAIN SHALL be ignored.
REQ-028 Latency from request acceptance to output SHALL be response latency + 1 cycle.
REQ-029 Fetch enables SHALL be 0 in every state except HOLD.

Reset
REQ-030 On rst=0 at a clock edge, from any state including mid-request, the FSM SHALL go to IDLE with pc=RESET_PC, icache_req=0, both enables 0, and all PC and instruction outputs 0.
REQ-031 A response arriving after reset SHALL be ignored.

Structure
REQ-032 A shared front-end package SHALL hold the FSM state enum, the RESET_PC default and the 32-bit instruction/PC width constant.
REQ-033 The output pair register with its hold and clear logic SHALL be the single sub-module fetch_pair_buffer.

Verification
REQ-034 Reset release, ready=1, rvalid one cycle later, stall=0 -> pairs 1C000000/1C000004 then 1C000008/1C00000C, both enables 1.
REQ-035 HOLD at pc 1C000000 with bpu_valid=1, bpu_taken=1, bpu_target=1C000104 -> the next icache_pc is 1C000104 and that pair has only fetch_inst_1_en=1, followed by 1C000108.
REQ-036 stall=1 for 3 cycles in HOLD -> outputs stable for 3 cycles, icache_req=0, then pc+8 requested.
REQ-037 flush with target 1C000200 in WAIT, rvalid 2 cycles later carrying 32'hDEADBEEF -> no enable is raised for that data, and the next request is 1C000200.
REQ-038 flush and bpu_taken in the same HOLD cycle -> flush_target wins; rst=0 asserted in WAIT -> IDLE, with a late rvalid ignored.
